id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage of the 5-stage MIPS core, directly upstream of the ALU. It captures decoded operands and control from ID, registers a 4-bit ALU control code decoded from ALUOp/funct, and drives the ALU `A`/`B` operands through a forwarding network fed from EX/MEM and MEM/WB. It also detects load-use hazards and inserts a bubble, signalling ID/IF to hold.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high; clears all pipeline registers
- `stall`  in  1  external hold (memory wait); the register keeps its contents
- `flush`  in  1  branch/jump squash; loads a bubble
- `id_valid`  in  1  ID holds a real instruction
- `id_rs_data`, `id_rt_data`  in  32  register-file read data
- `id_imm`  in  32  sign-extended immediate
- `id_rs`, `id_rt`, `id_rd`  in  5  register numbers
- `id_funct`  in  6  R-type function field
- `id_ALUOp`  in  2  main-decoder ALU operation class
- `id_ALUSrc`, `id_RegDst`, `id_RegWrite`, `id_MemRead`, `id_MemWrite`, `id_MemtoReg`  in  1 each  decoded controls
- `exmem_RegWrite`  in  1, `exmem_rd`  in  5, `exmem_result`  in  32  EX/MEM writeback source
- `memwb_RegWrite`  in  1, `memwb_rd`  in  5, `memwb_result`  in  32  MEM/WB writeback source
- `ALU_control`  out  4  to ALU
- `A`, `B`  out  32  ALU operands
- `store_data`  out  32  forwarded rt value for stores
- `ex_dest`  out  5  destination register
- `ex_valid`, `ex_RegWrite`, `ex_MemRead`, `ex_MemWrite`, `ex_MemtoReg`  out  1 each  registered controls
- `hazard_stall`  out  1  combinational; ID/IF must hold PC and IF/ID

## Operation
- ALU_control decode at capture:
  - ALUOp 00 → 0010 (add)
  - ALUOp 01 → 0110 (sub)
  - ALUOp 11 → 0111 (slt)
  - ALUOp 10 → funct: 100000→0010, 100010→0110, 100100→0000, 100101→0001, 101010→0111, 100111→1100; any other funct → 1111 (ALU passes A)
- `ex_dest` = RegDst ? `id_rd` : `id_rt`, captured at load.
- Bubble: `ex_valid`, all `ex_*` controls, `ex_dest`, and `ALU_control` are 0; data registers are 0.
- Register update priority on each rising edge: `reset` (async) > `flush` (bubble) > `stall` (hold) > `hazard_stall` (bubble) > load from ID. A load copies `id_valid` into `ex_valid`.
- Forwarding applies to both rs and rt paths:
  - Use `exmem_result` if `exmem_RegWrite` and `exmem_rd` ≠ 0 and `exmem_rd` equals the registered source.
  - Otherwise use `memwb_result` under the same rule with the memwb inputs.
  - Otherwise use the registered data.
  - EX/MEM has priority over MEM/WB.
- `A` = forwarded rs. `B` = `ALUSrc` ? registered imm : forwarded rt. `store_data` = forwarded rt.
- `hazard_stall` = `ex_valid` & `ex_MemRead` & `ex_dest` ≠ 0 & (`ex_dest` == `id_rs` | `ex_dest` == `id_rt`) & `id_valid`. It is gated low while `flush` is high.

## Timing
- Latency is 1 cycle from ID inputs to registered outputs. `A`, `B`, and `store_data` are combinational from registered state plus the forwarding inputs in the same cycle.
- Reset value: every registered output is 0. `A`, `B`, and `store_data` are therefore 0 when the forwarding inputs are idle.
- Reset mid-operation: state clears immediately without waiting for `clk`; the first load occurs on the first edge after `reset` falls.
- Simultaneous `flush` and `stall`: flush wins and a bubble is loaded.
- A load-use hazard yields exactly one bubble cycle. On the following cycle the loaded value arrives through the `memwb` forward.

## Configuration
- `ID_EX_FORWARD_EN` defined: forwarding network as above; `hazard_stall` covers load-use only.
- Undefined:
  - Forwarding inputs are ignored; `A`/`B`/`store_data` use registered data only.
  - `hazard_stall` asserts for any RAW hazard: `id_valid` and a nonzero source matching either `ex_dest` (with `ex_valid` & `ex_RegWrite`) or `exmem_rd` (with `exmem_RegWrite`).
  - The register file writes in the first half-cycle, so MEM/WB needs no check.

## Test plan
- Reset mid-run, then load `add` (ALUOp 10, funct 100000, rs_data 5, rt_data 7) → after one edge: `ALU_control`=0010, `A`=5, `B`=7, `ex_valid`=1.
- `exmem_RegWrite`=1, `exmem_rd`=rs=8, `exmem_result`=0xAA, with memwb also matching at value 0xBB → `A`=0xAA (EX/MEM priority). Repeat with `exmem_rd`=0 and rs=0 → no forward.
- Load `lw` into EX with dest 9; ID holds `sub` using rs=9 → `hazard_stall`=1; next edge gives `ex_valid`=0 and all controls 0; the following cycle forwards `memwb_result`.
- `flush`=1 and `stall`=1 on the same edge → bubble loaded. `stall` alone for 3 cycles → outputs hold unchanged.
- ALUOp 10 with funct 100111 → 1100; funct 000000 → 1111; ALUOp 01 → 0110; `ALUSrc`=1 with imm 0xFFFFFFFC → `B`=0xFFFFFFFC.
- Without `ID_EX_FORWARD_EN`: `add` in EX writing $3, ID reads $3 → `hazard_stall`=1 and `A` is taken from registered data.

Source files
------------

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with ALU control decode, operand forwarding and hazard detection
// Optional feature macro: ID_EX_FORWARD_EN (EX/MEM and MEM/WB forwarding; otherwise stall on any RAW hazard)
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [5:0]  id_funct,
  input  logic [1:0]  id_ALUOp,
  input  logic        id_ALUSrc,
  input  logic        id_RegDst,
  input  logic        id_RegWrite,
  input  logic        id_MemRead,
  input  logic        id_MemWrite,
  input  logic        id_MemtoReg,
  input  logic        exmem_RegWrite,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_RegWrite,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  output logic [3:0]  ALU_control,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [31:0] store_data,
  output logic [4:0]  ex_dest,
  output logic        ex_valid,
  output logic        ex_RegWrite,
  output logic        ex_MemRead,
  output logic        ex_MemWrite,
  output logic        ex_MemtoReg,
  output logic        hazard_stall
);

  logic        valid_q, valid_d;
  logic        regwrite_q, regwrite_d;
  logic        memread_q, memread_d;
  logic        memwrite_q, memwrite_d;
  logic        memtoreg_q, memtoreg_d;
  logic        alusrc_q, alusrc_d;
  logic [4:0]  dest_q, dest_d;
  logic [3:0]  alu_ctrl_q, alu_ctrl_d;
  logic [4:0]  rs_q, rs_d;
  logic [4:0]  rt_q, rt_d;
  logic [31:0] rs_data_q, rs_data_d;
  logic [31:0] rt_data_q, rt_data_d;
  logic [31:0] imm_q, imm_d;

  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;

  function automatic logic [3:0] alu_decode(input logic [1:0] op, input logic [5:0] funct);
    logic [3:0] code;
    code = 4'b1111;
    case (op)
      2'b00: code = 4'b0010;
      2'b01: code = 4'b0110;
      2'b11: code = 4'b0111;
      default: begin
        case (funct)
          6'b100000: code = 4'b0010;
          6'b100010: code = 4'b0110;
          6'b100100: code = 4'b0000;
          6'b100101: code = 4'b0001;
          6'b101010: code = 4'b0111;
          6'b100111: code = 4'b1100;
          default:   code = 4'b1111;
        endcase
      end
    endcase
    return code;
  endfunction

`ifdef ID_EX_FORWARD_EN
  // Only a load in EX cannot be forwarded in time; everything else is covered by the bypass.
  always_comb begin
    hazard_stall = 1'b0;
    if (!flush && id_valid && valid_q && memread_q && (dest_q != 5'd0) &&
        ((dest_q == id_rs) || (dest_q == id_rt)))
      hazard_stall = 1'b1;
  end

  always_comb begin
    fwd_rs = rs_data_q;
    if (exmem_RegWrite && (exmem_rd != 5'd0) && (exmem_rd == rs_q))
      fwd_rs = exmem_result;
    else if (memwb_RegWrite && (memwb_rd != 5'd0) && (memwb_rd == rs_q))
      fwd_rs = memwb_result;
  end

  always_comb begin
    fwd_rt = rt_data_q;
    if (exmem_RegWrite && (exmem_rd != 5'd0) && (exmem_rd == rt_q))
      fwd_rt = exmem_result;
    else if (memwb_RegWrite && (memwb_rd != 5'd0) && (memwb_rd == rt_q))
      fwd_rt = memwb_result;
  end
`else
  logic raw_ex;
  logic raw_mem;
  logic unused_fwd;

  // MEM/WB is not checked: the register file writes in the first half-cycle.
  always_comb begin
    raw_ex  = valid_q && regwrite_q && (dest_q != 5'd0) &&
              ((dest_q == id_rs) || (dest_q == id_rt));
    raw_mem = exmem_RegWrite && (exmem_rd != 5'd0) &&
              ((exmem_rd == id_rs) || (exmem_rd == id_rt));
    hazard_stall = 1'b0;
    if (!flush && id_valid && (raw_ex || raw_mem))
      hazard_stall = 1'b1;
  end

  assign fwd_rs     = rs_data_q;
  assign fwd_rt     = rt_data_q;
  assign unused_fwd = ^{exmem_result, memwb_RegWrite, memwb_rd, memwb_result, rs_q, rt_q};
`endif

  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    memtoreg_d = memtoreg_q;
    alusrc_d   = alusrc_q;
    dest_d     = dest_q;
    alu_ctrl_d = alu_ctrl_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rs_data_d  = rs_data_q;
    rt_data_d  = rt_data_q;
    imm_d      = imm_q;
    if (flush || (!stall && hazard_stall)) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      alusrc_d   = 1'b0;
      dest_d     = 5'd0;
      alu_ctrl_d = 4'd0;
      rs_d       = 5'd0;
      rt_d       = 5'd0;
      rs_data_d  = 32'd0;
      rt_data_d  = 32'd0;
      imm_d      = 32'd0;
    end else if (!stall) begin
      valid_d    = id_valid;
      regwrite_d = id_RegWrite;
      memread_d  = id_MemRead;
      memwrite_d = id_MemWrite;
      memtoreg_d = id_MemtoReg;
      alusrc_d   = id_ALUSrc;
      dest_d     = id_RegDst ? id_rd : id_rt;
      alu_ctrl_d = alu_decode(id_ALUOp, id_funct);
      rs_d       = id_rs;
      rt_d       = id_rt;
      rs_data_d  = id_rs_data;
      rt_data_d  = id_rt_data;
      imm_d      = id_imm;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      alusrc_q   <= 1'b0;
      dest_q     <= 5'd0;
      alu_ctrl_q <= 4'd0;
      rs_q       <= 5'd0;
      rt_q       <= 5'd0;
      rs_data_q  <= 32'd0;
      rt_data_q  <= 32'd0;
      imm_q      <= 32'd0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      memtoreg_q <= memtoreg_d;
      alusrc_q   <= alusrc_d;
      dest_q     <= dest_d;
      alu_ctrl_q <= alu_ctrl_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm_q      <= imm_d;
    end
  end

  assign ALU_control = alu_ctrl_q;
  assign A           = fwd_rs;
  assign B           = alusrc_q ? imm_q : fwd_rt;
  assign store_data  = fwd_rt;
  assign ex_dest     = dest_q;
  assign ex_valid    = valid_q;
  assign ex_RegWrite = regwrite_q;
  assign ex_MemRead  = memread_q;
  assign ex_MemWrite = memwrite_q;
  assign ex_MemtoReg = memtoreg_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed table-driven bench for id_ex_stage
module tb_id_ex_stage;

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk, reset, stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [5:0]  id_funct;
  logic [1:0]  id_ALUOp;
  logic        id_ALUSrc, id_RegDst, id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg;
  logic        exmem_RegWrite, memwb_RegWrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [3:0]  ALU_control;
  logic [31:0] A, B, store_data;
  logic [4:0]  ex_dest;
  logic        ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, hazard_stall;

  int n_cmp = 0;
  int n_bad = 0;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct), .id_ALUOp(id_ALUOp),
    .id_ALUSrc(id_ALUSrc), .id_RegDst(id_RegDst), .id_RegWrite(id_RegWrite),
    .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_MemtoReg(id_MemtoReg),
    .exmem_RegWrite(exmem_RegWrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_RegWrite(memwb_RegWrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ALU_control(ALU_control), .A(A), .B(B), .store_data(store_data), .ex_dest(ex_dest),
    .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_MemtoReg(ex_MemtoReg), .hazard_stall(hazard_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  funct;
    logic        alusrc, regdst, regwrite, memread, memwrite, memtoreg;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_data, rt_data, imm;
    logic [3:0]  exp_ctl;
    logic [31:0] exp_a, exp_b;
    logic [4:0]  exp_dest;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input logic [1:0] op, input logic [5:0] funct,
                              input logic [5:0] ctl_bits,
                              input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic [31:0] rs_data, input logic [31:0] rt_data,
                              input logic [31:0] imm, input logic [3:0] exp_ctl,
                              input logic [31:0] exp_a, input logic [31:0] exp_b,
                              input logic [4:0] exp_dest);
    vec_t v;
    v.op = op; v.funct = funct;
    {v.alusrc, v.regdst, v.regwrite, v.memread, v.memwrite, v.memtoreg} = ctl_bits;
    v.rs = rs; v.rt = rt; v.rd = rd;
    v.rs_data = rs_data; v.rt_data = rt_data; v.imm = imm;
    v.exp_ctl = exp_ctl; v.exp_a = exp_a; v.exp_b = exp_b; v.exp_dest = exp_dest;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input vec_t v);
    id_valid = 1'b1;
    id_ALUOp = v.op; id_funct = v.funct;
    id_ALUSrc = v.alusrc; id_RegDst = v.regdst; id_RegWrite = v.regwrite;
    id_MemRead = v.memread; id_MemWrite = v.memwrite; id_MemtoReg = v.memtoreg;
    id_rs = v.rs; id_rt = v.rt; id_rd = v.rd;
    id_rs_data = v.rs_data; id_rt_data = v.rt_data; id_imm = v.imm;
  endtask

  task automatic fwd_idle();
    exmem_RegWrite = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
    memwb_RegWrite = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
  endtask

  task automatic flush_step();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    // ctl_bits = {alusrc, regdst, regwrite, memread, memwrite, memtoreg}
    vecs[0]  = mk(2'b10, 6'b100000, 6'b011000, 5'd1,  5'd2,  5'd3,  32'd5,        32'd7,      32'h10,       4'b0010, 32'd5,        32'd7,        5'd3);
    vecs[1]  = mk(2'b10, 6'b100010, 6'b011000, 5'd4,  5'd5,  5'd6,  32'd100,      32'd30,     32'h0,        4'b0110, 32'd100,      32'd30,       5'd6);
    vecs[2]  = mk(2'b10, 6'b100100, 6'b011000, 5'd7,  5'd8,  5'd10, 32'hF0F0,     32'h0FF0,   32'h0,        4'b0000, 32'hF0F0,     32'h0FF0,     5'd10);
    vecs[3]  = mk(2'b10, 6'b100101, 6'b011000, 5'd11, 5'd12, 5'd13, 32'd1,        32'd2,      32'h0,        4'b0001, 32'd1,        32'd2,        5'd13);
    vecs[4]  = mk(2'b10, 6'b101010, 6'b011000, 5'd14, 5'd15, 5'd16, 32'hFFFFFFFF, 32'd1,      32'h0,        4'b0111, 32'hFFFFFFFF, 32'd1,        5'd16);
    vecs[5]  = mk(2'b10, 6'b100111, 6'b011000, 5'd17, 5'd18, 5'd19, 32'hAAAA0000, 32'h5555,   32'h0,        4'b1100, 32'hAAAA0000, 32'h5555,     5'd19);
    vecs[6]  = mk(2'b10, 6'b000000, 6'b011000, 5'd20, 5'd21, 5'd22, 32'd9,        32'd10,     32'h0,        4'b1111, 32'd9,        32'd10,       5'd22);
    vecs[7]  = mk(2'b01, 6'b100000, 6'b000000, 5'd23, 5'd24, 5'd25, 32'd3,        32'd3,      32'h0,        4'b0110, 32'd3,        32'd3,        5'd24);
    vecs[8]  = mk(2'b00, 6'b000000, 6'b101101, 5'd26, 5'd27, 5'd28, 32'h1000,     32'h77,     32'hFFFFFFFC, 4'b0010, 32'h1000,     32'hFFFFFFFC, 5'd27);
    vecs[9]  = mk(2'b11, 6'b000000, 6'b101000, 5'd29, 5'd30, 5'd31, 32'd4,        32'h99,     32'd5,        4'b0111, 32'd4,        32'd5,        5'd30);
    vecs[10] = mk(2'b00, 6'b000000, 6'b100010, 5'd1,  5'd2,  5'd3,  32'h2000,     32'hDEAD,   32'd8,        4'b0010, 32'h2000,     32'd8,        5'd2);

    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    set_id(vecs[0]);
    id_valid = 1'b0;
    fwd_idle();
    #1;
    chk("rst_ctl", ALU_control, 4'd0);
    chk("rst_A", A, 32'd0);
    chk("rst_B", B, 32'd0);
    chk("rst_sd", store_data, 32'd0);
    chk("rst_dest", ex_dest, 5'd0);
    chk("rst_valid", ex_valid, 1'b0);
    chk("rst_ctrls", {ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg}, 4'd0);
    #12 reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      flush_step();
      set_id(vecs[i]);
      step();
      chk($sformatf("v%0d_ctl", i), ALU_control, vecs[i].exp_ctl);
      chk($sformatf("v%0d_A", i), A, vecs[i].exp_a);
      chk($sformatf("v%0d_B", i), B, vecs[i].exp_b);
      chk($sformatf("v%0d_sd", i), store_data, vecs[i].rt_data);
      chk($sformatf("v%0d_dest", i), ex_dest, vecs[i].exp_dest);
      chk($sformatf("v%0d_valid", i), ex_valid, 1'b1);
      chk($sformatf("v%0d_rw", i), ex_RegWrite, vecs[i].regwrite);
      chk($sformatf("v%0d_mr", i), ex_MemRead, vecs[i].memread);
      chk($sformatf("v%0d_mw", i), ex_MemWrite, vecs[i].memwrite);
      chk($sformatf("v%0d_m2r", i), ex_MemtoReg, vecs[i].memtoreg);
    end

    // Asynchronous reset between edges, then first load on the next edge.
    flush_step();
    set_id(vecs[0]);
    step();
    chk("mr_pre_valid", ex_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("mr_valid", ex_valid, 1'b0);
    chk("mr_ctl", ALU_control, 4'd0);
    chk("mr_A", A, 32'd0);
    chk("mr_dest", ex_dest, 5'd0);
    #1 reset = 1'b0;
    step();
    chk("mr_load_ctl", ALU_control, 4'b0010);
    chk("mr_load_A", A, 32'd5);
    chk("mr_load_B", B, 32'd7);
    chk("mr_load_valid", ex_valid, 1'b1);

    // Forwarding priority and the $0 exclusion.
    flush_step();
    set_id(mk(2'b10, 6'b100000, 6'b011000, 5'd8, 5'd9, 5'd10, 32'h11, 32'h22, 32'h0, 4'b0010, 32'h11, 32'h22, 5'd10));
    step();
    id_valid = 1'b0;
    exmem_RegWrite = 1'b1; exmem_rd = 5'd8; exmem_result = 32'hAA;
    memwb_RegWrite = 1'b1; memwb_rd = 5'd8; memwb_result = 32'hBB;
    #1;
    chk("fw_exmem_prio_A", A, FWD ? 32'hAA : 32'h11);
    exmem_RegWrite = 1'b0;
    #1;
    chk("fw_memwb_A", A, FWD ? 32'hBB : 32'h11);
    exmem_RegWrite = 1'b1; exmem_rd = 5'd9;
    #1;
    chk("fw_rt_B", B, FWD ? 32'hAA : 32'h22);
    chk("fw_rt_sd", store_data, FWD ? 32'hAA : 32'h22);
    chk("fw_rs_mix_A", A, FWD ? 32'hBB : 32'h11);
    fwd_idle();
    #1;
    chk("fw_idle_A", A, 32'h11);
    chk("fw_idle_B", B, 32'h22);
    flush_step();
    set_id(mk(2'b10, 6'b100000, 6'b011000, 5'd0, 5'd0, 5'd10, 32'h33, 32'h44, 32'h0, 4'b0010, 32'h33, 32'h44, 5'd10));
    step();
    exmem_RegWrite = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hAA;
    memwb_RegWrite = 1'b1; memwb_rd = 5'd0; memwb_result = 32'hBB;
    #1;
    chk("fw_r0_A", A, 32'h33);
    chk("fw_r0_B", B, 32'h44);
    fwd_idle();

    // Load-use: one bubble, then the loaded value through MEM/WB.
    flush_step();
    set_id(mk(2'b00, 6'b000000, 6'b101101, 5'd1, 5'd9, 5'd0, 32'h100, 32'h0, 32'd4, 4'b0010, 32'h100, 32'd4, 5'd9));
    step();
    chk("lu_lw_dest", ex_dest, 5'd9);
    set_id(mk(2'b10, 6'b100010, 6'b011000, 5'd9, 5'd2, 5'd10, 32'h55, 32'h3, 32'h0, 4'b0110, 32'h0, 32'h3, 5'd10));
    #1;
    chk("lu_hazard", hazard_stall, 1'b1);
    step();
    chk("lu_bub_valid", ex_valid, 1'b0);
    chk("lu_bub_ctl", ALU_control, 4'd0);
    chk("lu_bub_ctrls", {ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg}, 4'd0);
    chk("lu_bub_dest", ex_dest, 5'd0);
    chk("lu_bub_A", A, 32'd0);
    chk("lu_hazard_clr", hazard_stall, 1'b0);
    memwb_RegWrite = 1'b1; memwb_rd = 5'd9; memwb_result = 32'h1234;
    step();
    chk("lu_sub_valid", ex_valid, 1'b1);
    chk("lu_sub_ctl", ALU_control, 4'b0110);
    chk("lu_sub_A", A, FWD ? 32'h1234 : 32'h55);
    chk("lu_sub_B", B, 32'h3);
    fwd_idle();

    // Flush beats stall; stall alone holds.
    flush_step();
    set_id(vecs[0]);
    step();
    chk("fs_pre_valid", ex_valid, 1'b1);
    flush = 1'b1; stall = 1'b1;
    step();
    chk("fs_valid", ex_valid, 1'b0);
    chk("fs_ctl", ALU_control, 4'd0);
    chk("fs_A", A, 32'd0);
    chk("fs_dest", ex_dest, 5'd0);
    flush = 1'b0; stall = 1'b0;
    step();
    chk("st_load_ctl", ALU_control, 4'b0010);
    stall = 1'b1;
    set_id(vecs[1]);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("st%0d_ctl", c), ALU_control, 4'b0010);
      chk($sformatf("st%0d_A", c), A, 32'd5);
      chk($sformatf("st%0d_B", c), B, 32'd7);
      chk($sformatf("st%0d_dest", c), ex_dest, 5'd3);
      chk($sformatf("st%0d_valid", c), ex_valid, 1'b1);
    end
    stall = 1'b0;
    step();
    chk("st_rel_ctl", ALU_control, 4'b0110);
    chk("st_rel_A", A, 32'd100);

    // RAW on a non-load: stalls only without the bypass network.
    flush_step();
    set_id(vecs[0]);
    step();
    set_id(mk(2'b10, 6'b100010, 6'b011000, 5'd3, 5'd4, 5'd5, 32'h66, 32'h8, 32'h0, 4'b0110, 32'h0, 32'h0, 5'd5));
    #1;
    chk("raw_ex_hazard", hazard_stall, FWD ? 1'b0 : 1'b1);
    chk("raw_ex_A", A, 32'd5);
    flush = 1'b1;
    #1;
    chk("raw_flush_gate", hazard_stall, 1'b0);
    step();
    flush = 1'b0;
    exmem_RegWrite = 1'b1; exmem_rd = 5'd4; exmem_result = 32'h9;
    #1;
    chk("raw_mem_hazard", hazard_stall, FWD ? 1'b0 : 1'b1);
    exmem_rd = 5'd0;
    #1;
    chk("raw_mem_r0", hazard_stall, 1'b0);
    exmem_rd = 5'd4; id_valid = 1'b0;
    #1;
    chk("raw_invalid", hazard_stall, 1'b0);
    fwd_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
